// File: rtl/sfx_pkg.sv
// Shared effect ids, note codes, ROM entry layout and FSM state encoding for the
// sound-effect scheduler and its note ROM.
package sfx_pkg;

  localparam int SFX_HIT   = 0;
  localparam int SFX_MISS  = 1;
  localparam int SFX_PAUSE = 2;
  localparam int SFX_WIN   = 3;

  localparam int ROM_NOTE_W = 6;
  localparam int ROM_DUR_W  = 6;
  localparam int ENTRY_W    = ROM_NOTE_W + ROM_DUR_W;

  typedef logic [ROM_NOTE_W-1:0] note_t;
  typedef logic [ROM_DUR_W-1:0]  dur_t;

  localparam note_t NOTE_REST = 6'd0;
  localparam note_t NOTE_C3 = 6'd1,  NOTE_D3 = 6'd2,  NOTE_E3 = 6'd3,  NOTE_F3 = 6'd4;
  localparam note_t NOTE_G3 = 6'd5,  NOTE_A3 = 6'd6,  NOTE_B3 = 6'd7;
  localparam note_t NOTE_C4 = 6'd8,  NOTE_D4 = 6'd9,  NOTE_E4 = 6'd10, NOTE_F4 = 6'd11;
  localparam note_t NOTE_G4 = 6'd12, NOTE_A4 = 6'd13, NOTE_B4 = 6'd14;
  localparam note_t NOTE_C5 = 6'd15, NOTE_D5 = 6'd16, NOTE_E5 = 6'd17, NOTE_F5 = 6'd18;
  localparam note_t NOTE_G5 = 6'd19, NOTE_A5 = 6'd20, NOTE_B5 = 6'd21;

  typedef struct packed {
    note_t note;
    dur_t  dur;
  } sfx_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_PLAY = 2'd2
  } state_e;

endpackage

// File: rtl/sfx_rom.sv
// Note/duration table for every effect; any unlisted {sfx, idx} returns dur=0,
// which the scheduler treats as the end-of-effect marker.
module sfx_rom
  import sfx_pkg::*;
#(
  parameter int SFX_W = 2,
  parameter int IDX_W = 4
) (
  input  logic [SFX_W-1:0] sfx_i,
  input  logic [IDX_W-1:0] idx_i,
  output sfx_entry_t       entry_o
);

  function automatic logic [SFX_W+IDX_W-1:0] key(input int sfx, input int idx);
    return {SFX_W'(sfx), IDX_W'(idx)};
  endfunction

  // NOTE: the default assignment ahead of the case keeps this block free of latches.
  always_comb begin
    entry_o = '0;
    case ({sfx_i, idx_i})
      key(SFX_HIT, 0):   entry_o = '{NOTE_C4, 6'd2};
      key(SFX_HIT, 1):   entry_o = '{NOTE_E4, 6'd1};
      key(SFX_MISS, 0):  entry_o = '{NOTE_E3, 6'd1};
      key(SFX_MISS, 1):  entry_o = '{NOTE_REST, 6'd1};
      key(SFX_MISS, 2):  entry_o = '{NOTE_D3, 6'd2};
      key(SFX_PAUSE, 0): entry_o = '{NOTE_C5, 6'd1};
      key(SFX_PAUSE, 1): entry_o = '{NOTE_E5, 6'd1};
      key(SFX_WIN, 0):   entry_o = '{NOTE_C4, 6'd1};
      key(SFX_WIN, 1):   entry_o = '{NOTE_E4, 6'd1};
      key(SFX_WIN, 2):   entry_o = '{NOTE_G4, 6'd1};
      key(SFX_WIN, 3):   entry_o = '{NOTE_C5, 6'd1};
      key(SFX_WIN, 4):   entry_o = '{NOTE_REST, 6'd1};
      key(SFX_WIN, 5):   entry_o = '{NOTE_C5, 6'd1};
      key(SFX_WIN, 6):   entry_o = '{NOTE_E5, 6'd1};
      key(SFX_WIN, 7):   entry_o = '{NOTE_G5, 6'd2};
      default:           entry_o = '0;
    endcase
  end

endmodule

// File: rtl/sfx_scheduler.sv
// Latches sound-effect requests and plays the highest-priority pending effect on the
// buzzer note bus. Define SFX_PREEMPT_EN to let a higher-priority request abort a playing effect.
module sfx_scheduler
  import sfx_pkg::*;
#(
  parameter int NUM_SFX   = 4,
  parameter int TICK_DIV  = 1_000_000,
  parameter int MAX_NOTES = 8,
  parameter int NOTE_W    = 6
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       enabled,
  input  logic [NUM_SFX-1:0]         sfx_req,
  output logic [NOTE_W-1:0]          note,
  output logic                       busy,
  output logic [$clog2(NUM_SFX)-1:0] cur_sfx,
  output logic                       sfx_done
);

  localparam int SFX_W  = $clog2(NUM_SFX);
  localparam int IDX_W  = $clog2(MAX_NOTES + 1);
  localparam int TICK_W = $clog2(TICK_DIV);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [IDX_W-1:0]  IDX_END   = IDX_W'(MAX_NOTES);

  state_e              state_q;
  logic [NUM_SFX-1:0]  pending_q;
  logic [NUM_SFX-1:0]  pending_clr;
  logic [IDX_W-1:0]    idx_q;
  logic [TICK_W-1:0]   tick_q;
  dur_t                dur_q;
  logic [NOTE_W-1:0]   note_q;
  logic [SFX_W-1:0]    cur_q;
  logic [SFX_W-1:0]    sel;
  logic                done_q;
  logic                preempt;
  sfx_entry_t          rom_entry;

  sfx_rom #(.SFX_W(SFX_W), .IDX_W(IDX_W)) u_rom (
    .sfx_i   (cur_q),
    .idx_i   (idx_q),
    .entry_o (rom_entry)
  );

  // NOTE: blocking assignments in combinational logic; later iterations override, so the highest set bit wins.
  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_SFX; i++) begin
      if (pending_q[i]) sel = SFX_W'(i);
    end
  end

  always_comb begin
    pending_clr = '0;
    if (state_q == ST_IDLE && |pending_q) pending_clr[sel] = 1'b1;
  end

`ifdef SFX_PREEMPT_EN
  // A request arriving this cycle counts too, so the abort lands on the next edge.
  always_comb begin
    preempt = 1'b0;
    for (int i = 0; i < NUM_SFX; i++) begin
      if (i > int'(cur_q) && (pending_q[i] || sfx_req[i])) preempt = 1'b1;
    end
  end
`else
  assign preempt = 1'b0;
`endif

  // NOTE: state registers use non-blocking assignments so every branch sees pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      pending_q <= '0;
      idx_q     <= '0;
      tick_q    <= '0;
      dur_q     <= '0;
      note_q    <= '0;
      cur_q     <= '0;
      done_q    <= 1'b0;
    end else if (!enabled) begin
      state_q   <= ST_IDLE;
      pending_q <= '0;
      idx_q     <= '0;
      tick_q    <= '0;
      dur_q     <= '0;
      note_q    <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      pending_q <= (pending_q & ~pending_clr) | sfx_req;
      case (state_q)
        ST_IDLE: begin
          note_q <= '0;
          if (|pending_q) begin
            cur_q   <= sel;
            idx_q   <= '0;
            state_q <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (preempt) begin
            note_q  <= '0;
            state_q <= ST_IDLE;
          end else if (rom_entry.dur == '0 || idx_q == IDX_END) begin
            note_q  <= '0;
            done_q  <= 1'b1;
            state_q <= ST_IDLE;
          end else begin
            note_q  <= NOTE_W'(rom_entry.note);
            dur_q   <= rom_entry.dur;
            tick_q  <= '0;
            state_q <= ST_PLAY;
          end
        end
        ST_PLAY: begin
          if (preempt) begin
            note_q  <= '0;
            state_q <= ST_IDLE;
          end else if (tick_q == TICK_LAST) begin
            tick_q <= '0;
            if (dur_q != '0) dur_q <= dur_q - 1'b1;
            if (dur_q <= ROM_DUR_W'(1)) begin
              idx_q   <= idx_q + 1'b1;
              state_q <= ST_LOAD;
            end
          end else begin
            tick_q <= tick_q + 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign note     = note_q;
  assign busy     = (state_q != ST_IDLE);
  assign cur_sfx  = cur_q;
  assign sfx_done = done_q;

endmodule
